// File: rtl/wb_dmem_pkg.sv
// wb_dmem_pkg: shared FSM state type and width constants for the wb_dmem
// Wishbone data memory.
package wb_dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int MAX_WAIT_STATES = 7;
    localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);
    localparam int ADR_W           = 32;

endpackage

// File: rtl/wb_dmem_ctrl.sv
// wb_dmem_ctrl: IDLE/WAIT/RESP handshake FSM with wait-state down-counter.
// Dropping cyc_i while waiting abandons the transfer.
module wb_dmem_ctrl
    import wb_dmem_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cyc_i,
    input  logic stb_i,
    output logic sample,
    output logic enter_resp
);

    localparam logic [CNT_W-1:0] LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: if (cyc_i && stb_i) begin
                sample  = 1'b1;
                state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                cnt_d   = LOAD;
            end
            WAIT: if (!cyc_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (cnt_q == '0) begin
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // RESP always falls back to IDLE, so a RESP next-state means entry.
    assign enter_resp = state_d == RESP;

endmodule

// File: rtl/wb_dmem.sv
// wb_dmem: Wishbone classic data memory with byte lanes and wait states.
// Define WB_DMEM_ERR_EN to flag out-of-window addresses with err_o instead of wrapping.
module wb_dmem
    import wb_dmem_pkg::*;
#(
    parameter int               DATA_W      = 32,
    parameter int               DEPTH       = 1024,
    parameter int               WAIT_STATES = 0,
    parameter logic [ADR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic [ADR_W-1:0]    adr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic [DATA_W-1:0]   dat_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o
);

    localparam int               BYTES     = DATA_W / 8;
    localparam int               OFF_W     = $clog2(BYTES);
    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [ADR_W-1:0] MEM_BYTES = ADR_W'(DEPTH * BYTES);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADR_W-1:0]  off, word;
    logic [IDX_W-1:0]  idx_in, idx_q, idx;
    logic              err_in, err_q, err_cur;
    logic              we_q, we_cur;
    logic [BYTES-1:0]  sel_q;
    logic [DATA_W-1:0] dat_q;
    logic              sample, enter_resp;
    logic              unused_word;

    wb_dmem_ctrl #(.WAIT_STATES(WAIT_STATES)) u_ctrl (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .sample    (sample),
        .enter_resp(enter_resp)
    );

    assign off         = adr_i - BASE_ADDR;
    assign word        = off >> OFF_W;
    assign idx_in      = word[IDX_W-1:0];
    assign unused_word = ^word[ADR_W-1:IDX_W];

`ifdef WB_DMEM_ERR_EN
    assign err_in = off >= MEM_BYTES;
`else
    assign err_in = 1'b0;
`endif

    // With no wait states the response is built on the sampling edge itself.
    assign idx     = sample ? idx_in : idx_q;
    assign err_cur = sample ? err_in : err_q;
    assign we_cur  = sample ? we_i : we_q;

    always_ff @(posedge clk_i) begin
        if (sample) begin
            idx_q <= idx_in;
            err_q <= err_in;
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= dat_i;
        end
        if (rst_ni && ack_o && we_q)
            for (int b = 0; b < BYTES; b++)
                if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= enter_resp && !err_cur;
            err_o <= enter_resp && err_cur;
            if (enter_resp && (err_cur || !we_cur)) dat_o <= err_cur ? '0 : mem[idx];
        end
    end

endmodule

// File: tb/tb_wb_dmem.sv
// tb_wb_dmem: three wb_dmem instances (0, 3 and 2 wait states, 16 words) driven
// with directed and random transfers against an array-based memory model.
module tb_wb_dmem;

    localparam int WSV [3] = '{0, 3, 2};
`ifdef WB_DMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic [31:0] adr   [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [31:0] dat   [3];
    logic [31:0] rdat  [3];
    logic        ack   [3];
    logic        err   [3];

    logic [31:0] mdl     [3][16];
    logic [31:0] exp_dat [3];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_dmem #(
            .DATA_W     (32),
            .DEPTH      (16),
            .WAIT_STATES(WSV[g]),
            .BASE_ADDR  (32'h0)
        ) dut (
            .clk_i (clk),
            .rst_ni(rst_n[g]),
            .cyc_i (cyc[g]),
            .stb_i (stb[g]),
            .adr_i (adr[g]),
            .we_i  (we[g]),
            .sel_i (sel[g]),
            .dat_i (dat[g]),
            .dat_o (rdat[g]),
            .ack_o (ack[g]),
            .err_o (err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge after the response cycle.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        int ws;
        int ix;
        logic e;
        ws = WSV[k];
        e  = ERR && (a >= 32'h40);
        ix = int'(a[5:2]);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat[k] = d;
        @(posedge clk);
        #1;
        stb[k] = 1'b0; we[k] = 1'($urandom); adr[k] = $urandom; sel[k] = 4'($urandom); dat[k] = $urandom;
        if (e) exp_dat[k] = '0;
        else if (!w) exp_dat[k] = mdl[k][ix];
        for (int j = 0; j <= ws; j++) begin
            @(negedge clk);
            check($sformatf("ack%0d_c%0d", k, j), 32'(ack[k]), 32'(j == ws && !e));
            check($sformatf("err%0d_c%0d", k, j), 32'(err[k]), 32'(j == ws && e));
        end
        check($sformatf("dat%0d_resp", k), rdat[k], exp_dat[k]);
        if (!e && w)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[k][ix][8*b +: 8] = d[8*b +: 8];
        cyc[k] = 1'b0;
        @(negedge clk);
        check($sformatf("ack%0d_after", k), 32'(ack[k] | err[k]), 32'd0);
        check($sformatf("dat%0d_hold", k), rdat[k], exp_dat[k]);
    endtask

    task automatic quiet(input int k, input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check(tag, 32'(ack[k] | err[k]), 32'd0);
        end
    endtask

    initial begin
        int n;
        logic [31:0] old;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0; adr[k] = '0;
            we[k] = 1'b0; sel[k] = '0; dat[k] = '0; exp_dat[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
            check($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("rst_dat%0d", k), rdat[k], 32'd0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) xfer(k, 1'b1, 32'(i * 4), 4'hF, $urandom);

        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
        check("rd_deadbeef", rdat[0], 32'hDEAD_BEEF);

        xfer(0, 1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF);
        xfer(0, 1'b1, 32'h04, 4'b0101, 32'h0000_0000);
        xfer(0, 1'b0, 32'h04, 4'hF, 32'h0);
        check("byte_lanes", rdat[0], 32'hFF00_FF00);
        xfer(0, 1'b1, 32'h04, 4'h0, 32'h1234_5678);
        xfer(0, 1'b0, 32'h07, 4'h0, 32'h0);
        check("sel_zero", rdat[0], 32'hFF00_FF00);

        xfer(0, 1'b1, 32'h00, 4'hF, 32'h0BAD_F00D);
        xfer(0, 1'b1, 32'h40, 4'hF, 32'hCAFE_0040);
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0);
        check("oob_read", rdat[0], ERR ? 32'h0 : 32'hCAFE_0040);
        xfer(0, 1'b0, 32'h00, 4'hF, 32'h0);
        check("alias_base", rdat[0], ERR ? 32'h0BAD_F00D : 32'hCAFE_0040);

        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h20; sel[1] = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack[1] && n < 20);
        check("ws3_first", 32'(n), 32'd4);
        check("ws3_dat", rdat[1], mdl[1][8]);
        n = 0;
        do begin @(negedge clk); n++; end while (!ack[1] && n < 20);
        check("ws3_gap", 32'(n), 32'd5);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        exp_dat[1] = mdl[1][8];
        quiet(1, 2, "ws3_stop");

        old = mdl[2][2];
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h08; sel[2] = 4'hF; dat[2] = ~old;
        @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        quiet(2, 4, "abort_quiet");
        xfer(2, 1'b0, 32'h08, 4'hF, 32'h0);
        check("abort_mem", rdat[2], old);

        old = mdl[2][3];
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h0C; sel[2] = 4'hF; dat[2] = ~old;
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", 32'(ack[2]), 32'd0);
        check("mid_rst_err", 32'(err[2]), 32'd0);
        check("mid_rst_dat", rdat[2], 32'd0);
        rst_n[2] = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
        exp_dat[2] = '0;
        quiet(2, 4, "rst_quiet");
        xfer(2, 1'b0, 32'h0C, 4'hF, 32'h0);
        check("rst_mem", rdat[2], old);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 40; i++)
                xfer(k, 1'($urandom), 32'($urandom_range(0, 127)), 4'($urandom), $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_dmem.md
WB_DMEM -- requirements
Module: wb_dmem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_W-bit words; power of two, at least 16.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles before termination; legal range 0..7.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address; aligned to DEPTH*DATA_W/8.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port cyc_i, input, 1, Wishbone cycle.
REQ-008 SHALL have port stb_i, input, 1, Wishbone strobe.
REQ-009 SHALL have port adr_i, input, 32, byte address.
REQ-010 SHALL have port we_i, input, 1, write enable.
REQ-011 SHALL have port sel_i, input, DATA_W/8, byte lane selects.
REQ-012 SHALL have port dat_i, input, DATA_W, write data.
REQ-013 SHALL have port dat_o, output, DATA_W, read data, registered.
REQ-014 SHALL have port ack_o, output, 1, normal termination, registered.
REQ-015 SHALL have port err_o, output, 1, error termination, registered.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP; a request is cyc_i&stb_i.
REQ-017 In IDLE, a request SHALL latch adr_i, we_i, sel_i and dat_i, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-018 In WAIT, a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at zero the FSM SHALL go to RESP.
REQ-019 ack_o or err_o SHALL be high for exactly one cycle, in RESP, i.e. WAIT_STATES+1 cycles after the IDLE sampling edge; RESP always returns to IDLE.
REQ-020 Back-to-back throughput SHALL be one transfer per WAIT_STATES+2 cycles, since IDLE always follows RESP.
REQ-021 ack_o and err_o SHALL never be high together.
REQ-022 Word index SHALL be (adr_i-BASE_ADDR)>>log2(DATA_W/8), truncated to log2(DEPTH) bits; low address bits SHALL be ignored.
REQ-023 A write SHALL update only lanes with sel_i bit set, committed at the edge ending RESP with ack_o high; sel_i==0 SHALL be acked with no change.
REQ-024 A read SHALL load dat_o with the full word at the edge entering RESP; sel_i is ignored for reads.
REQ-025 dat_o SHALL hold its value outside RESP, and SHALL be 0 for an err_o response.
REQ-026 If cyc_i drops in WAIT, the FSM SHALL abort to IDLE next cycle with no ack_o/err_o and no write.
REQ-027 Input changes after the IDLE sampling edge SHALL be ignored until the next IDLE sample.

Reset
REQ-028 While rst_ni==0 at a clock edge, the FSM SHALL go to IDLE, the counter to 0, and ack_o, err_o and dat_o to 0.
REQ-029 Reset mid-transfer SHALL discard it without writing; memory contents SHALL NOT be reset.

Configuration
REQ-030 With WB_DMEM_ERR_EN defined, an address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) SHALL terminate with err_o at the normal latency, with no write.
REQ-031 Without WB_DMEM_ERR_EN, addresses SHALL wrap modulo the memory size, and err_o SHALL be tied to 0.

Structure
REQ-032 Package wb_dmem_pkg SHALL hold the FSM state enum, the legal WAIT_STATES maximum and the width helper constants.
REQ-033 FSM and wait counter SHALL sit in sub-module wb_dmem_ctrl; the storage array, lane writes and the output register SHALL be in wb_dmem.

Verification
REQ-034 WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with sel 4'hF, then read 0x10 -> each ack_o one cycle after sampling, dat_o=32'hDEADBEEF.
REQ-035 WAIT_STATES=3: read 0x20 -> ack_o high exactly 4 cycles after sampling, for one cycle; with cyc/stb held, next ack_o 5 cycles later.
REQ-036 Byte lanes: write 0xFFFFFFFF to 0x04, then write 0x00000000 with sel 4'b0101, then read -> 32'hFF00FF00.
REQ-037 With WB_DMEM_ERR_EN, DEPTH=16, BASE_ADDR=0: write to 0x40 -> err_o, no ack_o; read 0x00 unchanged, err read dat_o=0. Without the macro: write to 0x40 aliases 0x00.
REQ-038 WAIT_STATES=2: drop cyc_i one cycle into a write, or pull rst_ni low mid-transfer -> no ack_o, memory unchanged, FSM in IDLE, outputs 0 after reset.
